// File: rtl/sync_frame_serializer.sv
// Frame serializer: sends sync word 11101 then a DATA_W-bit payload MSB first,
// optionally zero-stuffing after every 1110 so 11101 only appears in the sync word.
module sync_frame_serializer #(
  parameter int DATA_W   = 8,
  parameter int STUFF_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dataout,
  output logic              dout_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [4:0] SYNC_WORD = 5'b11101;

  typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [3:0]        hist, hist_n;
  logic [2:0]        sidx, sidx_n;
  logic              bit_n, vld_n, done_n, ready_n;
  logic              accept, stuff;

  // din_ready is only ever high in IDLE, so it doubles as the accept qualifier.
  assign accept = din_valid && din_ready;
  assign stuff  = (STUFF_EN != 0) && (hist == 4'b1110);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      hist       <= '0;
      sidx       <= '0;
      dataout    <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      din_ready  <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      hist       <= hist_n;
      sidx       <= sidx_n;
      dataout    <= bit_n;
      dout_valid <= vld_n;
      busy       <= vld_n;
      frame_done <= done_n;
      din_ready  <= ready_n;
    end
  end

  // sidx counts sync bits already on the line; the 5th one hands over to PAYLOAD.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SYNC;
      SYNC:    if (sidx == 3'd4) state_n = PAYLOAD;
      PAYLOAD: if (cnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs and the datapath; each computes the
  // bit that will be on dataout during the following cycle.
  always_comb begin
    shreg_n = shreg;
    cnt_n   = cnt;
    hist_n  = hist;
    sidx_n  = sidx;
    bit_n   = 1'b0;
    vld_n   = 1'b0;
    done_n  = 1'b0;
    ready_n = 1'b0;
    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (accept) begin
          ready_n = 1'b0;
          bit_n   = SYNC_WORD[4];
          vld_n   = 1'b1;
          shreg_n = din;
          cnt_n   = CW'(DATA_W);
          hist_n  = {3'b000, SYNC_WORD[4]};
          sidx_n  = 3'd1;
        end
      end
      SYNC: begin
        bit_n  = SYNC_WORD[3'd4 - sidx];
        vld_n  = 1'b1;
        sidx_n = sidx + 3'd1;
        hist_n = {hist[2:0], bit_n};
      end
      PAYLOAD: begin
        if (cnt == '0) begin
          ready_n = 1'b1;
        end else if (stuff) begin
          bit_n  = 1'b0;
          vld_n  = 1'b1;
          hist_n = {hist[2:0], 1'b0};
        end else begin
          bit_n   = shreg[DATA_W-1];
          vld_n   = 1'b1;
          shreg_n = shreg << 1;
          cnt_n   = cnt - CW'(1);
          done_n  = (cnt == CW'(1));
          hist_n  = {hist[2:0], bit_n};
        end
      end
      default: ;
    endcase
  end

endmodule
